// File: rtl/line_code_pkg.sv
// Shared line-code definitions for the bit-level coder and receiver paths.
package line_code_pkg;

  localparam logic [1:0] CODE_ZERO = 2'b01;
  localparam logic [1:0] CODE_ONE  = 2'b10;

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } rx_state_t;

endpackage

// File: rtl/code_symbol_check.sv
// Combinational decode of one 2-bit line-code symbol into a data bit and a
// validity flag. Equal bit pairs (00/11) are never produced by the coder.
module code_symbol_check (
  input  logic [1:0] code,
  output logic       bit_o,
  output logic       invalid_o
);

  assign bit_o     = code[1];
  assign invalid_o = (code[0] == code[1]);

endmodule

// File: rtl/code_word_receiver.sv
// Assembles checked line-code symbols LSB-first into words on a valid/ready
// output, and reports invalid symbols with position and saturating count.
module code_word_receiver
  import line_code_pkg::*;
#(
  parameter int WORD_W = 23,
  parameter int CNT_W  = 8,
  parameter int POS_W  = $clog2(WORD_W)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [1:0]        code_i,
  input  logic              code_valid_i,
  output logic              code_ready_o,
  output logic [WORD_W-1:0] word_o,
  output logic              word_valid_o,
  input  logic              word_ready_i,
  output logic              error_o,
  output logic [POS_W-1:0]  err_pos_o,
  output logic [CNT_W-1:0]  err_cnt_o
);

  rx_state_t         r_state;
  rx_state_t         w_state_next;
  logic [POS_W-1:0]  r_bit_cnt;
  logic [WORD_W-1:0] r_asm;
  logic [WORD_W-1:0] w_asm_next;
  logic [WORD_W-1:0] r_word;
  logic              r_error;
  logic [POS_W-1:0]  r_err_pos;
  logic [CNT_W-1:0]  r_err_cnt;
  logic              w_bit;
  logic              w_invalid;
  logic              w_accept;
  logic              w_last;

  code_symbol_check u_check (
    .code      (code_i),
    .bit_o     (w_bit),
    .invalid_o (w_invalid)
  );

  assign w_accept = code_valid_i && (r_state == COLLECT);
  assign w_last   = (r_bit_cnt == POS_W'(WORD_W - 1));

  always_comb begin
    w_asm_next = r_asm;
    for (int i = 0; i < WORD_W; i++) begin
      if (r_bit_cnt == POS_W'(i)) w_asm_next[i] = w_bit;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= COLLECT;
    else         r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      COLLECT: if (w_accept && !w_invalid && w_last) w_state_next = HOLD;
      HOLD:    if (word_ready_i) w_state_next = COLLECT;
      default: w_state_next = COLLECT;
    endcase
  end

  // Stale bits in r_asm are harmless: every position is rewritten before
  // the word completes, since any abort restarts at bit 0.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_bit_cnt <= '0;
      r_asm     <= '0;
      r_word    <= '0;
      r_error   <= 1'b0;
      r_err_pos <= '0;
      r_err_cnt <= '0;
    end else begin
      r_error <= 1'b0;
      if (w_accept) begin
        if (w_invalid) begin
          r_error   <= 1'b1;
          r_err_pos <= r_bit_cnt;
          r_bit_cnt <= '0;
          if (r_err_cnt != {CNT_W{1'b1}}) r_err_cnt <= r_err_cnt + 1'b1;
        end else begin
          r_asm <= w_asm_next;
          if (w_last) begin
            r_bit_cnt <= '0;
            r_word    <= w_asm_next;
          end else begin
            r_bit_cnt <= r_bit_cnt + 1'b1;
          end
        end
      end
    end
  end

  assign code_ready_o = (r_state == COLLECT);
  assign word_valid_o = (r_state == HOLD);
  assign word_o       = r_word;
  assign error_o      = r_error;
  assign err_pos_o    = r_err_pos;
  assign err_cnt_o    = r_err_cnt;

endmodule

// File: tb/tb_code_word_receiver.sv
// Table-driven bench with word/error scoreboards for code_word_receiver.
module tb_code_word_receiver;

  localparam int WORD_W = 23;
  localparam int CNT_W  = 2;
  localparam int POS_W  = $clog2(WORD_W);

  logic              clk_i = 1'b0;
  logic              rst_ni;
  logic [1:0]        code_i;
  logic              code_valid_i;
  logic              code_ready_o;
  logic [WORD_W-1:0] word_o;
  logic              word_valid_o;
  logic              word_ready_i;
  logic              error_o;
  logic [POS_W-1:0]  err_pos_o;
  logic [CNT_W-1:0]  err_cnt_o;

  code_word_receiver #(.WORD_W(WORD_W), .CNT_W(CNT_W)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .code_i       (code_i),
    .code_valid_i (code_valid_i),
    .code_ready_o (code_ready_o),
    .word_o       (word_o),
    .word_valid_o (word_valid_o),
    .word_ready_i (word_ready_i),
    .error_o      (error_o),
    .err_pos_o    (err_pos_o),
    .err_cnt_o    (err_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [WORD_W-1:0] data;
    int                inv_pos;   // -1: full valid word
    logic [1:0]        inv_code;
    int                exp_cnt;
  } vec_t;

  typedef struct {
    int pos;
    int cnt;
  } err_t;

  int checks = 0;
  int errors = 0;
  logic [WORD_W-1:0] word_q[$];
  err_t              err_q[$];
  vec_t              tbl[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Drive one symbol and wait until it is accepted (bounded).
  task automatic send_sym(input logic [1:0] c, input int gap);
    bit acc;
    int bound;
    if (gap > 0) begin
      code_valid_i = 1'b0;
      code_i       = 2'b00;
      repeat (gap) begin
        @(posedge clk_i);
        #1;
      end
    end
    code_i       = c;
    code_valid_i = 1'b1;
    acc   = 1'b0;
    bound = 0;
    while (!acc && bound < 50) begin
      acc = code_ready_o;
      @(posedge clk_i);
      #1;
      bound++;
    end
    if (!acc) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_bits(input logic [WORD_W-1:0] d, input int n, input bit gapped);
    for (int i = 0; i < n; i++)
      send_sym(d[i] ? 2'b10 : 2'b01, gapped ? int'($urandom_range(1, 3)) : 0);
  endtask

  always @(negedge clk_i) begin
    if (rst_ni) begin
      if (word_valid_o && word_ready_i) begin
        if (word_q.size() == 0) chk("unexpected_word", {9'd0, word_o}, 32'd0);
        else chk("word", {9'd0, word_o}, {9'd0, word_q.pop_front()});
      end
      if (error_o) begin
        if (err_q.size() == 0) chk("unexpected_error", 32'd1, 32'd0);
        else begin
          err_t e;
          e = err_q.pop_front();
          chk("err_pos", {27'd0, err_pos_o}, e.pos);
          chk("err_cnt", {30'd0, err_cnt_o}, e.cnt);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout actual=running required=finished");
    $fatal(1);
  end

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_code_ready"}, {31'd0, code_ready_o}, 32'd1);
    chk({tag, "_word_o"}, {9'd0, word_o}, 32'd0);
    chk({tag, "_word_valid"}, {31'd0, word_valid_o}, 32'd0);
    chk({tag, "_error"}, {31'd0, error_o}, 32'd0);
    chk({tag, "_err_pos"}, {27'd0, err_pos_o}, 32'd0);
    chk({tag, "_err_cnt"}, {30'd0, err_cnt_o}, 32'd0);
  endtask

  initial begin
    logic [WORD_W-1:0] w1, w2, wg;
    err_t e;
    tbl[0] = '{data: 23'h7D2509, inv_pos: -1, inv_code: 2'b00, exp_cnt: 0};
    tbl[1] = '{data: 23'h7FFFFF, inv_pos:  7, inv_code: 2'b11, exp_cnt: 1};
    tbl[2] = '{data: 23'h012345, inv_pos: -1, inv_code: 2'b00, exp_cnt: 1};
    tbl[3] = '{data: 23'h3C3C3C, inv_pos: 22, inv_code: 2'b00, exp_cnt: 2};
    tbl[4] = '{data: 23'h000000, inv_pos:  0, inv_code: 2'b11, exp_cnt: 3};
    tbl[5] = '{data: 23'h7FFFFF, inv_pos:  3, inv_code: 2'b00, exp_cnt: 3};
    tbl[6] = '{data: 23'h1ABCDE, inv_pos: 15, inv_code: 2'b11, exp_cnt: 3};
    tbl[7] = '{data: 23'h2AAAAA, inv_pos: -1, inv_code: 2'b00, exp_cnt: 3};

    rst_ni       = 1'b0;
    code_i       = 2'b00;
    code_valid_i = 1'b0;
    word_ready_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    chk_reset_vals("init");
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;

    foreach (tbl[k]) begin
      if (tbl[k].inv_pos < 0) begin
        word_q.push_back(tbl[k].data);
        send_bits(tbl[k].data, WORD_W, 1'b0);
      end else begin
        e.pos = tbl[k].inv_pos;
        e.cnt = tbl[k].exp_cnt;
        err_q.push_back(e);
        send_bits(tbl[k].data, tbl[k].inv_pos, 1'b0);
        send_sym(tbl[k].inv_code, 0);
      end
    end
    code_valid_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    chk("table_words_drained", word_q.size(), 32'd0);
    chk("table_errs_drained", err_q.size(), 32'd0);
    chk("err_cnt_saturated", {30'd0, err_cnt_o}, 32'd3);

    // Backpressure: hold the word for 5 cycles with the next symbol pending.
    w1 = 23'h7D2509;
    w2 = 23'h5A0F3C;
    word_ready_i = 1'b0;
    word_q.push_back(w1);
    send_bits(w1, WORD_W, 1'b0);
    code_i       = w2[0] ? 2'b10 : 2'b01;
    code_valid_i = 1'b1;
    for (int c = 0; c < 5; c++) begin
      chk("bp_code_ready", {31'd0, code_ready_o}, 32'd0);
      chk("bp_word_valid", {31'd0, word_valid_o}, 32'd1);
      chk("bp_word_stable", {9'd0, word_o}, {9'd0, w1});
      @(posedge clk_i);
      #1;
    end
    word_ready_i = 1'b1;
    word_q.push_back(w2);
    send_bits(w2, WORD_W, 1'b0);
    code_valid_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    chk("bp_words_drained", word_q.size(), 32'd0);

    // Gapped input.
    wg = 23'h555555;
    word_q.push_back(wg);
    send_bits(wg, WORD_W, 1'b1);
    code_valid_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    chk("gap_words_drained", word_q.size(), 32'd0);

    // Reset mid-word: 10 symbols, then a short asynchronous pulse between edges.
    send_bits(23'h7FFFFF, 10, 1'b0);
    code_valid_i = 1'b0;
    #3;
    rst_ni = 1'b0;
    #1;
    chk_reset_vals("midrst");
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    word_q.push_back(23'h7D2509);
    send_bits(23'h7D2509, WORD_W, 1'b0);
    e.pos = 2;
    e.cnt = 1;
    err_q.push_back(e);
    send_bits(23'h000003, 2, 1'b0);
    send_sym(2'b11, 0);
    code_valid_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    chk("post_rst_words_drained", word_q.size(), 32'd0);
    chk("post_rst_errs_drained", err_q.size(), 32'd0);
    chk("post_rst_no_word", {31'd0, word_valid_o}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
